// File: rtl/user_io_seq_monitor.sv
// ---------------------------------------------------------------------------
// user_io_seq_monitor
//
// Watches the user I/O input bus and checks that an external agent drives
// the pattern 0x01, 0x02 ... 0x0A, 0xFF, 0x00 in order. Each value must be
// seen for STABLE_CYCLES consecutive synchronized cycles before it counts.
// Values that do not match the one currently expected (glitches, repeats,
// stray data) are ignored and never cause a failure.
//
// Optional feature (compile-time macro IO_SEQ_TIMEOUT_EN):
//   Defined   -> a per-step timeout counter is built. If a step takes
//                TIMEOUT_CYCLES cycles without acceptance, the block goes
//                to FAIL.
//   Undefined -> no timeout counter; fail is tied low and WAIT lasts until
//                the sequence completes, clear, or reset.
//
// Ports:
//   wb_clk_i   in   1      single clock, rising edge
//   wb_rst_i   in   1      synchronous active-high reset
//   io_in      in   WIDTH  asynchronous pad inputs
//   start      in   1      1-cycle pulse: begin/restart at step 0
//   clear      in   1      1-cycle pulse: abort to IDLE, clear status
//   busy       out  1      high while in WAIT
//   pass       out  1      sticky: full sequence seen
//   fail       out  1      sticky: timeout hit
//   done       out  1      1-cycle pulse on entering PASS or FAIL
//   step       out  4      index of currently expected value, 0..11
//   dbg_state  out  2      FSM state (0 IDLE, 1 WAIT, 2 PASS, 3 FAIL)
//
// Control pulses: start and clear are single-cycle requests with no
// handshake; they are acted on in the cycle they are sampled. clear has
// priority over start, and start has priority over any acceptance or
// timeout in the same cycle.
// ---------------------------------------------------------------------------
module user_io_seq_monitor #(
  parameter int WIDTH          = 8,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [WIDTH-1:0] io_in,
  input  logic             start,
  input  logic             clear,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic             done,
  output logic [3:0]       step,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  localparam int               CNT_W     = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       LAST_STEP = 4'd11;

  logic [WIDTH-1:0] s1_d, s1_q;
  logic [WIDTH-1:0] s2_d, s2_q;
  state_t           state_d, state_q;
  logic [3:0]       step_d, step_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             pass_d, pass_q;
  logic             done_d, done_q;
  logic             in_wait;
  logic             match;
  logic             accept;
  logic             timeout_hit;

  // Expected value for a step index, truncated/extended to the bus width.
  function automatic logic [WIDTH-1:0] exp_val(input logic [3:0] idx);
    logic [7:0] v;
    if (idx <= 4'd9) begin
      v = {4'd0, idx} + 8'd1;
    end else if (idx == 4'd10) begin
      v = 8'hFF;
    end else begin
      v = 8'h00;
    end
    return WIDTH'(v);
  endfunction

  // -------------------------------------------------------------------------
  // Two-flop synchronizer. No reset: whatever it holds after reset is
  // flushed within two cycles, and the FSM sits in IDLE until start anyway.
  // -------------------------------------------------------------------------
  always_comb begin
    s1_d = io_in;
    s2_d = s1_q;
  end

  always_ff @(posedge wb_clk_i) begin
    s1_q <= s1_d;
    s2_q <= s2_d;
  end

  assign in_wait = (state_q == ST_WAIT);
  assign match   = (s2_q == exp_val(step_q));
  // The cycle that completes the stability window accepts the value.
  assign accept  = in_wait && match && (cnt_q == CNT_LAST);

  // -------------------------------------------------------------------------
  // Optional per-step timeout
  // -------------------------------------------------------------------------
`ifdef IO_SEQ_TIMEOUT_EN
  localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_d, tmo_q;
  logic             fail_d, fail_q;

  // The counter holds TIMEOUT_CYCLES-1 on the last allowed cycle, so the
  // FAIL edge lands exactly TIMEOUT_CYCLES cycles after the step began.
  // An acceptance in the same cycle wins and reloads the counter.
  assign timeout_hit = in_wait && (tmo_q == TMO_LAST) && !accept;

  always_comb begin
    tmo_d  = tmo_q;
    fail_d = fail_q;
    if (clear || start) begin
      tmo_d  = '0;
      fail_d = 1'b0;
    end else if (in_wait) begin
      if (accept) begin
        tmo_d = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
      if (timeout_hit) begin
        fail_d = 1'b1;
      end
    end else begin
      tmo_d = '0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      tmo_q  <= '0;
      fail_q <= 1'b0;
    end else begin
      tmo_q  <= tmo_d;
      fail_q <= fail_d;
    end
  end

  assign fail = fail_q;
`else
  assign timeout_hit = 1'b0;
  assign fail        = 1'b0;

  // TIMEOUT_CYCLES only matters when the timeout counter is built.
  if (TIMEOUT_CYCLES < 1) begin : g_tmo_param_unused
  end
`endif

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else if (start) begin
      state_d = ST_WAIT;
    end else if (in_wait) begin
      if (accept && (step_q == LAST_STEP)) begin
        state_d = ST_PASS;
      end else if (timeout_hit) begin
        state_d = ST_FAIL;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Step / stability counter / status datapath
  // -------------------------------------------------------------------------
  always_comb begin
    step_d = step_q;
    cnt_d  = cnt_q;
    pass_d = pass_q;
    done_d = 1'b0;
    if (clear || start) begin
      step_d = 4'd0;
      cnt_d  = '0;
      pass_d = 1'b0;
    end else if (in_wait) begin
      if (!match) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        if (step_q == LAST_STEP) begin
          // step stays at 11 in PASS so it still names the final value.
          pass_d = 1'b1;
          done_d = 1'b1;
        end else begin
          step_d = step_q + 4'd1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      if (timeout_hit) begin
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      step_q <= 4'd0;
      cnt_q  <= '0;
      pass_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      step_q <= step_d;
      cnt_q  <= cnt_d;
      pass_q <= pass_d;
      done_q <= done_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    busy      = in_wait;
    pass      = pass_q;
    done      = done_q;
    step      = step_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_user_io_seq_monitor.sv
// ---------------------------------------------------------------------------
// tb_user_io_seq_monitor
//
// Self-checking bench for user_io_seq_monitor (WIDTH=8, STABLE_CYCLES=4,
// TIMEOUT_CYCLES=100). Inputs are driven on the falling edge, outputs are
// sampled on the falling edge. Expected step values are pushed to exp_q as
// each pattern value is driven and popped when the hold period ends.
// Build with +define+IO_SEQ_TIMEOUT_EN to exercise the timeout path.
// ---------------------------------------------------------------------------
module tb_user_io_seq_monitor;

  localparam int WIDTH          = 8;
  localparam int STABLE_CYCLES  = 4;
  localparam int TIMEOUT_CYCLES = 100;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] io_in;
  logic             start;
  logic             clear;
  logic             busy;
  logic             pass;
  logic             fail;
  logic             done;
  logic [3:0]       step;
  logic [1:0]       dbg_state;

  logic [3:0]       exp_q[$];
  logic [WIDTH-1:0] seq_tbl [12];
  int               vec_cnt   = 0;
  int               err_cnt   = 0;
  int               done_seen = 0;

  user_io_seq_monitor #(
    .WIDTH         (WIDTH),
    .STABLE_CYCLES (STABLE_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .io_in    (io_in),
    .start    (start),
    .clear    (clear),
    .busy     (busy),
    .pass     (pass),
    .fail     (fail),
    .done     (done),
    .step     (step),
    .dbg_state(dbg_state)
  );

  // -------------------------------------------------------------------------
  // Clock / reset / monitors
  // -------------------------------------------------------------------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (done === 1'b1) done_seen++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // Drive pattern entries first..last, each held 'hold' cycles (>= 6 so the
  // acceptance has landed when the step is checked).
  task automatic run_seq(input int first, input int last, input int hold);
    logic [3:0] e;
    for (int i = first; i <= last; i++) begin
      exp_q.push_back((i < 11) ? 4'(i + 1) : 4'd11);
      io_in = seq_tbl[i];
      tick(hold);
      e = exp_q.pop_front();
      vec_cnt++;
      if (step !== e) begin
        err_cnt++;
        $display("FAIL seq_step[%0d]: got %0d want %0d", i, step, e);
      end
    end
  endtask

  // -------------------------------------------------------------------------
  // Scenarios
  // -------------------------------------------------------------------------
  task automatic test_reset();
    vec_cnt++;
    if ({busy, pass, fail, done, step, dbg_state} !== 10'b0) begin
      err_cnt++;
      $display("FAIL reset_state: got b%0d p%0d f%0d d%0d s%0d st%0d want all 0",
               busy, pass, fail, done, step, dbg_state);
    end
  endtask

  task automatic test_full_seq();
    int d0;
    pulse_start();
    vec_cnt++;
    if ({busy, pass, step} !== {1'b1, 1'b0, 4'd0}) begin
      err_cnt++;
      $display("FAIL start_wait: got busy=%0d pass=%0d step=%0d want 1 0 0", busy, pass, step);
    end
    d0 = done_seen;
    run_seq(0, 11, 6);
    vec_cnt++;
    if ({pass, fail, busy, dbg_state} !== {3'b100, 2'd2}) begin
      err_cnt++;
      $display("FAIL full_pass: got pass=%0d fail=%0d busy=%0d st=%0d want 1 0 0 2",
               pass, fail, busy, dbg_state);
    end
    tick(3);
    vec_cnt++;
    if (done_seen - d0 !== 1) begin
      err_cnt++;
      $display("FAIL full_done_count: got %0d want 1", done_seen - d0);
    end
    vec_cnt++;
    if ({pass, step} !== {1'b1, 4'd11}) begin
      err_cnt++;
      $display("FAIL pass_sticky: got pass=%0d step=%0d want 1 11", pass, step);
    end
  endtask

  task automatic test_short_hold();
    pulse_start();
    // Latency: driven just after edge E, accepted on edge E+6.
    io_in = seq_tbl[0];
    tick(5);
    vec_cnt++;
    if (step !== 4'd0) begin
      err_cnt++;
      $display("FAIL latency_early: got %0d want 0", step);
    end
    tick(1);
    vec_cnt++;
    if (step !== 4'd1) begin
      err_cnt++;
      $display("FAIL latency_accept: got %0d want 1", step);
    end
    run_seq(1, 3, 6);
    // 0x05 held one cycle short, then 0x06: must stall at step 4.
    io_in = 8'h05;
    tick(STABLE_CYCLES - 1);
    io_in = 8'h06;
    tick(6);
    vec_cnt++;
    if (step !== 4'd4) begin
      err_cnt++;
      $display("FAIL short_hold_stall: got %0d want 4", step);
    end
    // 0x05 held exactly STABLE_CYCLES: accepted.
    io_in = 8'h05;
    tick(STABLE_CYCLES);
    io_in = 8'h06;
    tick(2);
    vec_cnt++;
    if (step !== 4'd5) begin
      err_cnt++;
      $display("FAIL exact_hold_accept: got %0d want 5", step);
    end
    tick(4);
    vec_cnt++;
    if (step !== 4'd6) begin
      err_cnt++;
      $display("FAIL resume_after_stall: got %0d want 6", step);
    end
    run_seq(6, 11, 6);
    vec_cnt++;
    if (pass !== 1'b1) begin
      err_cnt++;
      $display("FAIL short_hold_pass: got %0d want 1", pass);
    end
  endtask

  task automatic test_glitch();
    logic [WIDTH-1:0] g;
    logic [3:0]       e;
    pulse_start();
    for (int i = 0; i < 12; i++) begin
      g = seq_tbl[i] ^ (8'd1 << $urandom_range(0, 7));
      exp_q.push_back(4'(i));
      io_in = 8'h33;
      tick(2);
      io_in = g;
      tick(1);
      io_in = 8'h33;
      tick(1);
      e = exp_q.pop_front();
      vec_cnt++;
      if (step !== e) begin
        err_cnt++;
        $display("FAIL glitch_ignored[%0d]: got %0d want %0d", i, step, e);
      end
      run_seq(i, i, 6);
    end
    vec_cnt++;
    if ({pass, fail} !== 2'b10) begin
      err_cnt++;
      $display("FAIL glitch_pass: got pass=%0d fail=%0d want 1 0", pass, fail);
    end
  endtask

`ifdef IO_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    pulse_start();
    run_seq(0, 0, 6);
    io_in = 8'h00;
    for (int k = 1; k <= TIMEOUT_CYCLES + 1; k++) begin
      tick(1);
      if (k == TIMEOUT_CYCLES - 1) begin
        vec_cnt++;
        if ({fail, done, busy} !== 3'b001) begin
          err_cnt++;
          $display("FAIL timeout_early: got fail=%0d done=%0d busy=%0d want 0 0 1", fail, done, busy);
        end
      end else if (k == TIMEOUT_CYCLES) begin
        vec_cnt++;
        if ({fail, done, pass, busy, dbg_state} !== {4'b1100, 2'd3}) begin
          err_cnt++;
          $display("FAIL timeout_hit: got fail=%0d done=%0d pass=%0d busy=%0d st=%0d want 1 1 0 0 3",
                   fail, done, pass, busy, dbg_state);
        end
      end else if (k == TIMEOUT_CYCLES + 1) begin
        vec_cnt++;
        if ({fail, done} !== 2'b10) begin
          err_cnt++;
          $display("FAIL timeout_done_pulse: got fail=%0d done=%0d want 1 0", fail, done);
        end
      end
    end
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
  endtask
`else
  task automatic test_timeout();
    pulse_start();
    run_seq(0, 0, 6);
    io_in = 8'h00;
    tick(TIMEOUT_CYCLES + 50);
    vec_cnt++;
    if ({fail, busy, step} !== {2'b01, 4'd1}) begin
      err_cnt++;
      $display("FAIL no_timeout: got fail=%0d busy=%0d step=%0d want 0 1 1", fail, busy, step);
    end
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
  endtask
`endif

  task automatic test_clear_start();
    pulse_start();
    run_seq(0, 6, 6);
    clear = 1'b1;
    start = 1'b1;
    tick(1);
    clear = 1'b0;
    start = 1'b0;
    vec_cnt++;
    if ({busy, pass, step, dbg_state} !== 8'b0) begin
      err_cnt++;
      $display("FAIL clear_wins: got busy=%0d pass=%0d step=%0d st=%0d want 0 0 0 0",
               busy, pass, step, dbg_state);
    end
    io_in = seq_tbl[0];
    tick(8);
    vec_cnt++;
    if ({busy, step} !== 5'b0) begin
      err_cnt++;
      $display("FAIL idle_ignores_io: got busy=%0d step=%0d want 0 0", busy, step);
    end
    pulse_start();
    run_seq(0, 11, 6);
    vec_cnt++;
    if (pass !== 1'b1) begin
      err_cnt++;
      $display("FAIL clear_restart_pass: got %0d want 1", pass);
    end
  endtask

  task automatic test_reset_mid();
    pulse_start();
    run_seq(0, 8, 6);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    vec_cnt++;
    if ({busy, pass, fail, done, step, dbg_state} !== 10'b0) begin
      err_cnt++;
      $display("FAIL reset_mid: got b%0d p%0d f%0d d%0d s%0d st%0d want all 0",
               busy, pass, fail, done, step, dbg_state);
    end
    for (int i = 0; i < 3; i++) begin
      io_in = seq_tbl[i];
      tick(6);
    end
    vec_cnt++;
    if ({busy, pass, step, dbg_state} !== 8'b0) begin
      err_cnt++;
      $display("FAIL reset_ignores_io: got busy=%0d pass=%0d step=%0d st=%0d want 0 0 0 0",
               busy, pass, step, dbg_state);
    end
  endtask

  task automatic test_back_to_back();
    int d0;
    pulse_start();
    run_seq(0, 11, 6);
    // Restart straight from PASS, then run at the minimum hold time.
    d0 = done_seen;
    pulse_start();
    vec_cnt++;
    if ({busy, pass, step} !== {1'b1, 1'b0, 4'd0}) begin
      err_cnt++;
      $display("FAIL restart_from_pass: got busy=%0d pass=%0d step=%0d want 1 0 0", busy, pass, step);
    end
    for (int i = 0; i < 12; i++) begin
      io_in = seq_tbl[i];
      tick(STABLE_CYCLES);
    end
    tick(2);
    vec_cnt++;
    if ({pass, step, busy} !== {1'b1, 4'd11, 1'b0}) begin
      err_cnt++;
      $display("FAIL min_hold_pass: got pass=%0d step=%0d busy=%0d want 1 11 0", pass, step, busy);
    end
    vec_cnt++;
    if (done_seen - d0 !== 1) begin
      err_cnt++;
      $display("FAIL min_hold_done_count: got %0d want 1", done_seen - d0);
    end
  endtask

  // -------------------------------------------------------------------------
  // Main sequence and report
  // -------------------------------------------------------------------------
  initial begin
    for (int i = 0; i < 10; i++) seq_tbl[i] = 8'(i + 1);
    seq_tbl[10] = 8'hFF;
    seq_tbl[11] = 8'h00;
    rst   = 1'b1;
    io_in = 8'h00;
    start = 1'b0;
    clear = 1'b0;
    tick(3);
    rst = 1'b0;

    test_reset();
    test_full_seq();
    test_short_hold();
    test_glitch();
    test_timeout();
    test_clear_start();
    test_reset_mid();
    test_back_to_back();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
